vram_line_scheduler: RTL and testbench

- Time-shares one 16-bit synchronous video RAM between a CPU port and the scanline fetcher, driven by the raster counters of the 640x480 timing generator (25 MHz pixel clock).
- During horizontal blanking of each line it fetches the next display line (160 words, 4bpp, 4 pixels/word) into a single scanline buffer. The CPU owns the RAM at all other times.

---
 rtl/vram_line_scheduler_if.sv | 27 ++
 rtl/vram_line_scheduler.sv | 149 ++++++++++++++
 tb/tb_vram_line_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_line_scheduler_if.sv
// CPU request/ack bus and synchronous RAM command bus of the VRAM line scheduler.
// The scheduler is the slave on the CPU side and drives the RAM commands.
interface vram_line_scheduler_if #(
    parameter int unsigned ADDR_W = 17
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata;
    logic              cpu_ack;
    logic [15:0]       cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_line_scheduler.sv
// Time-shares one 16-bit synchronous VRAM between a CPU port and the scanline fetcher.
// The next display line is fetched during horizontal blanking; the CPU owns the RAM otherwise.
module vram_line_scheduler #(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned H_TOTAL        = 800,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned V_TOTAL        = 521,
    parameter int unsigned WORDS_PER_LINE = 160,
    parameter int unsigned ADDR_W         = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           raster_x,
    input  logic [9:0]           raster_y,
    input  logic [ADDR_W-1:0]    vid_base,
    vram_line_scheduler_if.slave bus,
    output logic                 lb_we,
    output logic [7:0]           lb_addr,
    output logic [15:0]          lb_wdata,
    output logic                 fetch_busy
);
    if (WORDS_PER_LINE != H_TOTAL - H_ACTIVE) begin : g_cfg_check
        $error("WORDS_PER_LINE must equal H_TOTAL - H_ACTIVE");
    end

    localparam logic [9:0] XFirst  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] XLast   = 10'(H_TOTAL - 2);
    localparam logic [9:0] YLast   = 10'(V_TOTAL - 1);
    localparam logic [9:0] YActive = 10'(V_ACTIVE);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    state_e              state_q, state_d;
    logic                cpu_we_q;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_wdata_q, mem_wdata_d;
    logic                busy_q;
    logic [7:0]          k_mem_q;
    logic                tag_vid_q;
    logic [7:0]          tag_k_q;
    logic                lb_we_q;
    logic [7:0]          lb_addr_q;
    logic [15:0]         lb_wdata_q;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [15:0]         cpu_rdata_q, cpu_rdata_d;

    logic [9:0]          tgt;
    logic                vid_dec;
    logic [ADDR_W-1:0]   vid_addr;
    logic [7:0]          k;
    logic                cpu_accept;

    // Decision for the command that appears on the bus next cycle.
    assign tgt      = (raster_y == YLast) ? '0 : raster_y + 10'd1;
    assign vid_dec  = (tgt < YActive) && (raster_x >= XFirst) && (raster_x <= XLast);
    assign vid_addr = (raster_x == XFirst && tgt == '0) ? vid_base : ptr_q;
    assign k        = 8'(raster_x - XFirst);

    always_comb begin
        state_d     = state_q;
        cpu_accept  = 1'b0;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = '0;
        case (state_q)
            StIdle: begin
                if (bus.cpu_req && !vid_dec) begin
                    cpu_accept = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                state_d     = StAck;
                cpu_ack_d   = 1'b1;
                cpu_rdata_d = cpu_we_q ? '0 : bus.mem_rdata;
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_en_d    = vid_dec | cpu_accept;
        mem_we_d    = cpu_accept & bus.cpu_we;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        ptr_d       = ptr_q;
        if (vid_dec) begin
            mem_addr_d = vid_addr;
            ptr_d      = vid_addr + ADDR_W'(1);
        end else if (cpu_accept) begin
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cpu_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            k_mem_q     <= '0;
            tag_vid_q   <= 1'b0;
            tag_k_q     <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            lb_wdata_q  <= '0;
            ptr_q       <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            if (cpu_accept) cpu_we_q <= bus.cpu_we;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= vid_dec;
            k_mem_q     <= vid_dec ? k : '0;
            // Tag travels with the read so CPU data never reaches the line buffer.
            tag_vid_q   <= busy_q;
            tag_k_q     <= k_mem_q;
            lb_we_q     <= tag_vid_q;
            lb_addr_q   <= tag_vid_q ? tag_k_q : '0;
            lb_wdata_q  <= tag_vid_q ? bus.mem_rdata : '0;
            ptr_q       <= ptr_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign lb_we         = lb_we_q;
    assign lb_addr       = lb_addr_q;
    assign lb_wdata      = lb_wdata_q;
    assign fetch_busy    = busy_q;
endmodule

// File: tb/tb_vram_line_scheduler.sv
// Bench for vram_line_scheduler: a RAM model, a scheduling model built from the raster rules,
// a per-cycle compare process and directed scenarios with hand-computed expectations.
module tb_vram_line_scheduler;
    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    raster_x;
    logic [9:0]    raster_y;
    logic [AW-1:0] vid_base;
    logic          lb_we;
    logic [7:0]    lb_addr;
    logic [15:0]   lb_wdata;
    logic          fetch_busy;

    vram_line_scheduler_if #(.ADDR_W(AW)) bus ();

    vram_line_scheduler #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .raster_x   (raster_x),
        .raster_y   (raster_y),
        .vid_base   (vid_base),
        .bus        (bus),
        .lb_we      (lb_we),
        .lb_addr    (lb_addr),
        .lb_wdata   (lb_wdata),
        .fetch_busy (fetch_busy)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (y=%0d x=%0d)", name, act, exp,
                     raster_y, raster_x);
        end
    endtask

    function automatic logic [15:0] init_word(input logic [AW-1:0] a);
        return 16'(a ^ 17'h05A3C);
    endfunction

    // Synchronous RAM: read data appears the cycle after the command.
    logic [15:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = init_word(AW'(i));
        bus.mem_rdata = 16'hDEAD;
        forever begin
            @(posedge clk);
            if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr];
            else bus.mem_rdata <= 16'hDEAD;
        end
    end

    typedef struct packed {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic          busy;
    } mem_exp_t;
    typedef struct packed {logic we; logic [7:0] addr; logic [15:0] data;} lb_exp_t;
    typedef struct packed {logic ack; logic [15:0] data;} ack_exp_t;

    mem_exp_t    exp_mem [8];
    lb_exp_t     exp_lb  [8];
    ack_exp_t    exp_ack [8];
    logic [15:0] mdl_mem [0:(1<<AW)-1];

    // Model: every cycle's raster/CPU inputs schedule expected bus, line-buffer and ack events.
    initial begin
        int unsigned   cyc = 0;
        int unsigned   m_free = 0;
        int unsigned   m_words = 0;
        int unsigned   s;
        logic [AW-1:0] m_base = '0;
        logic [AW-1:0] a;
        logic [9:0]    tgt;
        for (int i = 0; i < (1 << AW); i++) mdl_mem[i] = init_word(AW'(i));
        for (int i = 0; i < 8; i++) begin
            exp_mem[i] = '0;
            exp_lb[i]  = '0;
            exp_ack[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (reset) begin
                check("reset_mem_en", 32'(bus.mem_en), 32'd0);
                check("reset_cpu_ack", 32'(bus.cpu_ack), 32'd0);
                check("reset_lb_we", 32'(lb_we), 32'd0);
                check("reset_fetch_busy", 32'(fetch_busy), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    exp_mem[i] = '0;
                    exp_lb[i]  = '0;
                    exp_ack[i] = '0;
                end
                m_free  = 0;
                m_base  = '0;
                m_words = 0;
            end else begin
                s = cyc % 8;
                check("mem_en", 32'(bus.mem_en), 32'(exp_mem[s].en));
                check("fetch_busy", 32'(fetch_busy), 32'(exp_mem[s].busy));
                if (exp_mem[s].en) begin
                    check("mem_we", 32'(bus.mem_we), 32'(exp_mem[s].we));
                    check("mem_addr", 32'(bus.mem_addr), 32'(exp_mem[s].addr));
                    if (exp_mem[s].we || exp_mem[s].busy)
                        check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_mem[s].wdata));
                end
                check("lb_we", 32'(lb_we), 32'(exp_lb[s].we));
                if (exp_lb[s].we) begin
                    check("lb_addr", 32'(lb_addr), 32'(exp_lb[s].addr));
                    check("lb_wdata", 32'(lb_wdata), 32'(exp_lb[s].data));
                end
                check("cpu_ack", 32'(bus.cpu_ack), 32'(exp_ack[s].ack));
                if (exp_ack[s].ack) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_ack[s].data));
                exp_mem[s] = '0;
                exp_lb[s]  = '0;
                exp_ack[s] = '0;

                tgt = (raster_y == 10'd520) ? 10'd0 : raster_y + 10'd1;
                if (tgt < 10'd480 && raster_x >= 10'd639 && raster_x <= 10'd798) begin
                    if (raster_x == 10'd639 && tgt == 10'd0) begin
                        m_base  = vid_base;
                        m_words = 0;
                    end
                    a = m_base + AW'(m_words);
                    m_words++;
                    exp_mem[(cyc + 1) % 8] = '{en: 1'b1, we: 1'b0, addr: a, wdata: 16'h0,
                                               busy: 1'b1};
                    exp_lb[(cyc + 3) % 8]  = '{we: 1'b1, addr: 8'(raster_x - 10'd639),
                                               data: mdl_mem[a]};
                end else if (bus.cpu_req && cyc >= m_free) begin
                    exp_mem[(cyc + 1) % 8] = '{en: 1'b1, we: bus.cpu_we, addr: bus.cpu_addr,
                                               wdata: bus.cpu_wdata, busy: 1'b0};
                    exp_ack[(cyc + 3) % 8] = '{ack: 1'b1,
                                               data: bus.cpu_we ? 16'h0 : mdl_mem[bus.cpu_addr]};
                    if (bus.cpu_we) mdl_mem[bus.cpu_addr] = bus.cpu_wdata;
                    m_free = cyc + 4;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (raster_x == 10'd799) begin
            raster_x = '0;
            raster_y = (raster_y == 10'd520) ? 10'd0 : raster_y + 10'd1;
        end else begin
            raster_x = raster_x + 10'd1;
        end
    endtask

    task automatic set_raster(input int x, input int y);
        raster_x = 10'(x);
        raster_y = 10'(y);
    endtask

    task automatic tick_to(input int x, input int y);
        int n = 0;
        while (!(raster_x == 10'(x) && raster_y == 10'(y)) && n < 5000) begin
            tick();
            n++;
        end
        check("raster_reach", 32'({raster_y, raster_x}), 32'({10'(y), 10'(x)}));
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [15:0] wdata,
                              output int lat, output logic [15:0] rdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.cpu_ack !== 1'b1 && lat < 2000);
        check("cpu_ack_seen", 32'(bus.cpu_ack), 32'd1);
        rdata = bus.cpu_rdata;
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        reset         = 1'b1;
        vid_base      = 17'h01000;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        set_raster(0, 520);
        repeat (3) tick();
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_lb_we", 32'(lb_we), 32'd0);
        reset = 1'b0;
        set_raster(0, 520);

        // Frame start fetch for line 0, then line 1 continuing from there.
        tick_to(639, 520);
        check("pre_fetch_busy", 32'(fetch_busy), 32'd0);
        tick();
        check("first_vid_en", 32'(bus.mem_en), 32'd1);
        check("first_vid_busy", 32'(fetch_busy), 32'd1);
        check("first_vid_addr", 32'(bus.mem_addr), 32'h01000);
        tick_to(642, 520);
        check("lb0_we", 32'(lb_we), 32'd1);
        check("lb0_addr", 32'(lb_addr), 32'd0);
        check("lb0_data", 32'(lb_wdata), 32'h4A3C);
        tick_to(799, 520);
        check("last_vid_addr", 32'(bus.mem_addr), 32'h0109F);
        tick_to(1, 0);
        check("lb159_we", 32'(lb_we), 32'd1);
        check("lb159_addr", 32'(lb_addr), 32'd159);
        check("lb159_data", 32'(lb_wdata), 32'h4AA3);
        tick_to(2, 0);
        check("lb_after_159", 32'(lb_we), 32'd0);
        tick_to(640, 0);
        check("line1_addr", 32'(bus.mem_addr), 32'h010A0);

        // CPU write accepted at x=638 slots in just before the fetch.
        tick_to(638, 1);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 17'h00123;
        bus.cpu_wdata = 16'hBEEF;
        tick();
        check("bw_mem_we", 32'(bus.mem_we), 32'd1);
        check("bw_mem_addr", 32'(bus.mem_addr), 32'h00123);
        check("bw_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        check("bw_busy", 32'(fetch_busy), 32'd0);
        tick();
        check("bw_vid_busy", 32'(fetch_busy), 32'd1);
        check("bw_vid_addr", 32'(bus.mem_addr), 32'h01140);
        tick();
        check("bw_ack", 32'(bus.cpu_ack), 32'd1);
        check("bw_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("bw_lb_quiet", 32'(lb_we), 32'd0);
        bus.cpu_req = 1'b0;
        tick();
        check("bw_lb0_data", 32'(lb_wdata), 32'h4B7C);

        // CPU read issued at 639: its data returns at 640 and must not reach the line buffer.
        tick_to(638, 2);
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        repeat (3) tick();
        check("br_ack", 32'(bus.cpu_ack), 32'd1);
        check("br_rdata", 32'(bus.cpu_rdata), 32'hBEEF);
        check("br_lb_quiet", 32'(lb_we), 32'd0);
        bus.cpu_req = 1'b0;

        // Request inside the video window stalls until x=799.
        set_raster(630, 10);
        tick_to(639, 10);
        cpu_access(1'b0, 17'h01005, 16'h0, lat, rd);
        check("stall_lat", 32'(lat), 32'd163);
        check("stall_ack_pos", 32'({raster_y, raster_x}), 32'({10'd11, 10'd2}));
        check("stall_rdata", 32'(rd), 32'h4A39);

        // Vertical blank: no fetch, CPU served immediately.
        set_raster(630, 480);
        tick_to(700, 480);
        cpu_access(1'b0, 17'h00123, 16'h0, lat, rd);
        check("vb_lat", 32'(lat), 32'd3);
        check("vb_rdata", 32'(rd), 32'hBEEF);
        tick_to(720, 480);
        check("vb_busy", 32'(fetch_busy), 32'd0);
        check("vb_mem_en", 32'(bus.mem_en), 32'd0);

        // Reset during a CPU read in WAIT drops it.
        tick_to(750, 480);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 17'h00200;
        tick();
        check("rs_issue", 32'(bus.mem_en), 32'd1);
        tick();
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        #1;
        check("rs_async_en", 32'(bus.mem_en), 32'd0);
        check("rs_async_ack", 32'(bus.cpu_ack), 32'd0);
        check("rs_async_addr", 32'(bus.mem_addr), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rs_no_ack", 32'(bus.cpu_ack), 32'd0);
        end
        cpu_access(1'b0, 17'h00123, 16'h0, lat, rd);
        check("rs_idle_lat", 32'(lat), 32'd3);
        check("rs_idle_rdata", 32'(rd), 32'hBEEF);

        // New base mid-frame only takes effect at the next frame-start fetch.
        vid_base = 17'h02000;
        set_raster(600, 5);
        tick_to(640, 5);
        check("bc_old_ptr", 32'(bus.mem_addr), 32'h00000);
        check("bc_old_busy", 32'(fetch_busy), 32'd1);
        set_raster(630, 520);
        tick_to(640, 520);
        check("bc_new_base", 32'(bus.mem_addr), 32'h02000);
        tick_to(1, 0);
        check("bc_lb159_addr", 32'(lb_addr), 32'd159);
        check("bc_lb159_data", 32'(lb_wdata), 32'h7AA3);
        tick_to(640, 0);
        check("bc_line1_addr", 32'(bus.mem_addr), 32'h020A0);
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
